// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider for the RV64M DIV/DIVU/REM/REMU
// family and their W forms. One quotient bit per cycle, a sign-fix cycle,
// then a result register held until the consumer takes it.
module seq_divider #(
  parameter int XLEN = 64,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [OPW-1:0]  control,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_out
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  // decoded op select; unknown encodings fall back to DIVU
  typedef struct packed {
    logic is_uns;
    logic is_rem;
    logic is_w;
  } op_t;

  function automatic logic [XLEN-1:0] sext_w(input logic [HALF-1:0] v);
    return {{(XLEN-HALF){v[HALF-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext_w(input logic [HALF-1:0] v);
    return {{(XLEN-HALF){1'b0}}, v};
  endfunction

  state_t          state, state_n;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q, res_q;
  logic            qneg_q, rneg_q, rem_sel_q, w_q;

  op_t             op_in;
  logic [XLEN-1:0] a_prep, b_prep, a_abs, b_abs, spec_res;
  logic            a_neg, b_neg, div_zero, sgn_ovf, special;

  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] trial, rem_nxt, quo_nxt;
  logic [XLEN-1:0] q_fix, r_fix, sel, fix_res;

  // decode control into sign / quotient-vs-remainder / word-size
  always_comb begin
    op_in = '{is_uns: 1'b1, is_rem: 1'b0, is_w: 1'b0};
    if (control <= OPW'(7)) begin
      op_in.is_uns = control[0];
      op_in.is_rem = control[1];
      op_in.is_w   = control[2];
    end
  end

  // operand prep at accept: width extension, magnitudes, special cases
  always_comb begin
    a_prep = src1;
    b_prep = src2;
    if (op_in.is_w) begin
      a_prep = op_in.is_uns ? zext_w(src1[HALF-1:0]) : sext_w(src1[HALF-1:0]);
      b_prep = op_in.is_uns ? zext_w(src2[HALF-1:0]) : sext_w(src2[HALF-1:0]);
    end
    a_neg    = !op_in.is_uns && a_prep[XLEN-1];
    b_neg    = !op_in.is_uns && b_prep[XLEN-1];
    a_abs    = a_neg ? -a_prep : a_prep;
    b_abs    = b_neg ? -b_prep : b_prep;
    div_zero = (b_prep == '0);
    // only the full-width signed overflow is special; the W form of it
    // falls out of the normal path once sign-extended to 64 bits
    sgn_ovf  = !op_in.is_uns && !op_in.is_w &&
               (a_prep == {1'b1, {(XLEN-1){1'b0}}}) && (b_prep == '1);
    special  = div_zero || sgn_ovf;
    spec_res = '0;
    if (div_zero)
      spec_res = op_in.is_rem ? (op_in.is_w ? sext_w(a_prep[HALF-1:0]) : a_prep) : '1;
    else if (sgn_ovf)
      spec_res = op_in.is_rem ? '0 : a_prep;
  end

  // one restoring step; the shifted partial remainder needs XLEN+1 bits
  // because an unsigned divisor can occupy the full word
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = shifted >= {1'b0, dvsr_q};
    // when fits, the true difference is below dvsr_q, so the low bits suffice
    trial   = shifted[XLEN-1:0] - dvsr_q;
    rem_nxt = fits ? trial : shifted[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], fits};
  end

  // sign fix and result select for the FIX cycle
  always_comb begin
    q_fix   = qneg_q ? -quo_q : quo_q;
    r_fix   = rneg_q ? -rem_q : rem_q;
    sel     = rem_sel_q ? r_fix : q_fix;
    fix_res = w_q ? sext_w(sel[HALF-1:0]) : sel;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // next-state and handshake outputs; flush wins over everything but reset
  always_comb begin
    state_n   = state;
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    if (flush) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (in_valid) state_n = special ? S_DONE : S_CALC;
        S_CALC: if (cnt_q == '0) state_n = S_FIX;
        S_FIX:  state_n = S_DONE;
        S_DONE: if (out_ready) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // datapath: capture at accept, iterate in CALC, register result in FIX
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      res_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      rem_sel_q <= 1'b0;
      w_q       <= 1'b0;
    end else if (!flush) begin
      case (state)
        S_IDLE: if (in_valid) begin
          rem_q     <= '0;
          quo_q     <= a_abs;
          dvsr_q    <= b_abs;
          qneg_q    <= a_neg ^ b_neg;
          rneg_q    <= a_neg;
          rem_sel_q <= op_in.is_rem;
          w_q       <= op_in.is_w;
          cnt_q     <= CW'(XLEN-1);
          if (special) res_q <= spec_res;
        end
        S_CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - CW'(1);
        end
        S_FIX:  res_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign result_out = res_q;

  // the two handshake sides are never open at once
  assert property (@(posedge clk) disable iff (!rst_n) !(in_ready && out_valid));

endmodule
